alu_sequencer: RTL

Multi-cycle control sequencer for the 16-bit microcpu datapath. It fetches 16-bit instructions over a req/ack instruction-memory port and decodes them. It drives the ALU's operand, immediate and function inputs, writes ALU results into a local 4×16 register file, and keeps a snapshot of the ALU's clocked status flags for conditional branches. It is the initiating side of the ALU interface: it produces `a/b/imm_val/imm/func` and consumes `out/status_reg`.

---
 rtl/microcpu_pkg.sv | 53 +++++
 rtl/alu_sequencer_regfile.sv | 31 +++
 rtl/alu_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/microcpu_pkg.sv
// microcpu_pkg: shared constants and types for the microcpu sequencer.
// ALU function codes, status bit indexes, opcodes and FSM states.
package microcpu_pkg;

   localparam logic [3:0] FUNC_NOP = 4'd0;
   localparam logic [3:0] FUNC_ADD = 4'd1;
   localparam logic [3:0] FUNC_SUB = 4'd2;
   localparam logic [3:0] FUNC_MUL = 4'd3;
   localparam logic [3:0] FUNC_AND = 4'd4;
   localparam logic [3:0] FUNC_OR  = 4'd5;

   localparam int ST_EQU    = 0;
   localparam int ST_NEQU   = 1;
   localparam int ST_BTHAN  = 2;
   localparam int ST_BEQUAL = 3;
   localparam int ST_LTHAN  = 4;
   localparam int ST_LEQUAL = 5;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_MUL  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_LDI  = 4'h6;
   localparam logic [3:0] OP_ADDI = 4'h7;
   localparam logic [3:0] OP_CMP  = 4'h8;
   localparam logic [3:0] OP_BR   = 4'h9;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [2:0] BR_ALWAYS = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_FLAG,
      S_HALTED
   } seq_state_e;

   typedef struct packed {
      logic [3:0]  func;
      logic        imm;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] imm_val;
   } alu_drv_t;

   function automatic logic [15:0] sext8(input logic [7:0] v);
      return {{8{v[7]}}, v};
   endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// regfile4x16: four 16-bit registers, two async reads, one sync write.
// Asynchronous active-low reset clears every register.
module regfile4x16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  ra_addr,
   input  logic [1:0]  rb_addr,
   input  logic        wr_en,
   input  logic [1:0]  wr_addr,
   input  logic [15:0] wr_data,
   output logic [15:0] ra_data,
   output logic [15:0] rb_data
);

   logic [15:0] mem [4];

   assign ra_data = mem[ra_addr];
   assign rb_data = mem[rb_addr];

   // storage: clear on reset, single write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/execute control for the microcpu ALU.
// Define ALU_SEQ_MUL_EN to make opcode 3 (MUL) legal.
module alu_sequencer
   import microcpu_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [15:0]     imem_data,
   output logic [15:0]     alu_a,
   output logic [15:0]     alu_b,
   output logic [15:0]     alu_imm_val,
   output logic            alu_imm,
   output logic [3:0]      alu_func,
   input  logic [15:0]     alu_out,
   input  logic [7:0]      alu_status,
   output logic [PC_W-1:0] pc,
   output logic            busy,
   output logic            halted,
   output logic            illegal
);

   seq_state_e      state_q;
   seq_state_e      state_d;
   logic [PC_W-1:0] pc_q;
   logic [15:0]     ir_q;
   logic [7:0]      flags_q;
   logic            illegal_q;

   logic [3:0]  op;
   logic [1:0]  rd;
   logic [1:0]  ra;
   logic [1:0]  rb;
   logic [7:0]  imm8;
   logic [2:0]  cond;
   logic [15:0] ra_data;
   logic [15:0] rb_data;

   alu_drv_t drv;
   logic     dec_wr;
   logic     dec_flag;
   logic     dec_ill;
   logic     br_take;
   logic     exec;
   logic     fetch_hit;

   assign op   = ir_q[15:12];
   assign rd   = ir_q[11:10];
   assign ra   = ir_q[9:8];
   assign rb   = ir_q[7:6];
   assign imm8 = ir_q[7:0];
   assign cond = ir_q[11:9];

   assign exec      = (state_q == S_EXEC);
   assign fetch_hit = (state_q == S_FETCH) && imem_ack;

   regfile4x16 u_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .ra_addr (ra),
      .rb_addr (rb),
      .wr_en   (exec && dec_wr),
      .wr_addr (rd),
      .wr_data (alu_out),
      .ra_data (ra_data),
      .rb_data (rb_data)
   );

   // decode ir into ALU drive, write-back, flag capture and branch
   always_comb begin
      drv      = '0;
      dec_wr   = 1'b0;
      dec_flag = 1'b0;
      dec_ill  = 1'b0;
      br_take  = 1'b0;
      unique case (op)
         OP_NOP, OP_HALT: begin
         end
         OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            drv.func = op;
            drv.a    = ra_data;
            drv.b    = rb_data;
            dec_wr   = 1'b1;
            dec_flag = 1'b1;
         end
         OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
            drv.func = FUNC_MUL;
            drv.a    = ra_data;
            drv.b    = rb_data;
            dec_wr   = 1'b1;
            dec_flag = 1'b1;
`else
            dec_ill  = 1'b1;
`endif
         end
         OP_LDI: begin
            drv.func    = FUNC_NOP;
            drv.imm     = 1'b1;
            drv.imm_val = {8'h00, imm8};
            dec_wr      = 1'b1;
         end
         OP_ADDI: begin
            drv.func    = FUNC_ADD;
            drv.imm     = 1'b1;
            drv.imm_val = sext8(imm8);
            drv.b       = ra_data;
            dec_wr      = 1'b1;
            dec_flag    = 1'b1;
         end
         OP_CMP: begin
            drv.func = FUNC_SUB;
            drv.a    = ra_data;
            drv.b    = rb_data;
            dec_flag = 1'b1;
         end
         OP_BR: begin
            if (cond == BR_ALWAYS) begin
               br_take = 1'b1;
            end else if (cond < BR_ALWAYS) begin
               br_take = flags_q[cond];
            end
         end
         default: begin
            dec_ill = 1'b1;
         end
      endcase
   end

   // next state and fetch request
   always_comb begin
      state_d  = state_q;
      imem_req = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) state_d = S_EXEC;
         end
         S_EXEC: begin
            if (op == OP_HALT) state_d = S_HALTED;
            else if (dec_flag) state_d = S_FLAG;
            else               state_d = S_FETCH;
         end
         S_FLAG: begin
            state_d = S_FETCH;
         end
         S_HALTED: begin
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // pc, instruction, flag snapshot and sticky illegal
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         flags_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         if (fetch_hit) begin
            ir_q <= imem_data;
            pc_q <= pc_q + PC_W'(1);
         end else if (exec && br_take) begin
            pc_q <= PC_W'(imm8);
         end
         if (state_q == S_FLAG) flags_q <= alu_status;
         if (exec && dec_ill) illegal_q <= 1'b1;
      end
   end

   assign alu_func    = exec ? drv.func    : FUNC_NOP;
   assign alu_imm     = exec ? drv.imm     : 1'b0;
   assign alu_a       = exec ? drv.a       : '0;
   assign alu_b       = exec ? drv.b       : '0;
   assign alu_imm_val = exec ? drv.imm_val : '0;

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign busy      = (state_q != S_IDLE) && (state_q != S_HALTED);
   assign halted    = (state_q == S_HALTED);
   assign illegal   = illegal_q;

endmodule
